// File: rtl/psum_shiftreg.sv
// Purpose : multi-mode shift register (logical/arithmetic right, left, rotate right)
//           with a single-step idle shift and an FSM-driven multi-step shift of amt steps.
// Latency : start at edge k -> shifts on edges k+1..k+amt -> done for one cycle -> idle at k+amt+1.
// Backpressure: none; while busy, ld/sft/start and mode/amt changes are ignored (not queued).
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous clear of register, s_out and controller (highest priority)
//   ld, data_in   : parallel load (idle only)
//   s_in          : serial fill bit for logical-right and left modes (sampled live every step)
//   mode          : 00 logical right, 01 arithmetic right, 10 left, 11 rotate right
//   sft           : single idle step using the live mode
//   start, amt    : multi-step shift of amt steps using mode latched at start
//   data_out      : register contents
//   s_out         : last bit shifted out of the register
//   busy, done    : controller status (busy = not idle, done = one-cycle completion pulse)

module psum_shiftreg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] data_in,
   input  logic             s_in,
   input  logic [1:0]       mode,
   input  logic             sft,
   input  logic             start,
   input  logic [CNT_W-1:0] amt,
   output logic [WIDTH-1:0] data_out,
   output logic             s_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_LSL = 2'b10;

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic             s_out_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       mode_q;
   logic             busy_q;
   logic             done_q;

   logic [1:0]       step_mode;
   logic [WIDTH-1:0] step_dat;
   logic             step_bit;

   // A multi-step operation must not see later changes on the mode input,
   // so the stepper uses the mode captured at start while shifting.
   assign step_mode = (state == SHIFT) ? mode_q : mode;

   // One shift step of the current register value; step_bit is the bit
   // leaving the register, which becomes the new s_out.
   always_comb begin
      step_dat = data_q;
      step_bit = data_q[0];
      case (step_mode)
         MODE_LSR: begin
            step_dat = {s_in, data_q[WIDTH-1:1]};
            step_bit = data_q[0];
         end
         MODE_ASR: begin
            step_dat = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            step_bit = data_q[0];
         end
         MODE_LSL: begin
            step_dat = {data_q[WIDTH-2:0], s_in};
            step_bit = data_q[WIDTH-1];
         end
         default: begin
            step_dat = {data_q[0], data_q[WIDTH-1:1]};
            step_bit = data_q[0];
         end
      endcase
   end

   // Controller and datapath share one sequential block so that busy/done
   // are registered alongside the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         data_q  <= '0;
         s_out_q <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (clr) begin
         // Abort anything in flight without a done pulse.
         state   <= IDLE;
         data_q  <= '0;
         s_out_q <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ld) begin
                  // Load does not touch s_out.
                  data_q <= data_in;
               end else if (start) begin
                  busy_q <= 1'b1;
                  if (amt != '0) begin
                     mode_q <= mode;
                     cnt_q  <= amt;
                     state  <= SHIFT;
                  end else begin
                     // Zero-length request completes immediately, data untouched.
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end else if (sft) begin
                  data_q  <= step_dat;
                  s_out_q <= step_bit;
               end
            end

            SHIFT: begin
               data_q  <= step_dat;
               s_out_q <= step_bit;
               cnt_q   <= cnt_q - CNT_W'(1);
               // The step taken with the counter at 1 is the last one.
               if (cnt_q == CNT_W'(1)) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end

            DONE: begin
               // Start is not accepted here; always one cycle back to idle.
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               cnt_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_out = data_q;
   assign s_out    = s_out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_psum_shiftreg.sv
module tb_psum_shiftreg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       ld;
   logic [7:0] data_in;
   logic       s_in;
   logic [1:0] mode;
   logic       sft;
   logic       start;
   logic [3:0] amt;
   logic [7:0] data_out;
   logic       s_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   psum_shiftreg #(.WIDTH(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .ld       (ld),
      .data_in  (data_in),
      .s_in     (s_in),
      .mode     (mode),
      .sft      (sft),
      .start    (start),
      .amt      (amt),
      .data_out (data_out),
      .s_out    (s_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] init;
      logic [1:0] mode;
      logic       sin;
      logic [3:0] amt;
      logic       use_sft;
      logic [7:0] exp_dat;
      logic       exp_so;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one active edge, then settle before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ld(input logic [7:0] v);
      ld = 1'b1;
      data_in = v;
      tick();
      ld = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] m, input logic [3:0] a, input logic s);
      mode  = m;
      amt   = a;
      s_in  = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Count edges after the start edge until done is seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int nb;
      int nd;

      vecs[0]  = '{8'hB4, 2'b01, 1'b0, 4'd3,  1'b0, 8'hF6, 1'b1};
      vecs[1]  = '{8'h81, 2'b11, 1'b0, 4'd1,  1'b0, 8'hC0, 1'b1};
      vecs[2]  = '{8'h0F, 2'b10, 1'b1, 4'd2,  1'b0, 8'h3F, 1'b0};
      vecs[3]  = '{8'h00, 2'b00, 1'b1, 4'd0,  1'b1, 8'h80, 1'b0};
      vecs[4]  = '{8'h01, 2'b11, 1'b0, 4'd9,  1'b0, 8'h80, 1'b1};
      vecs[5]  = '{8'hFF, 2'b00, 1'b0, 4'd15, 1'b0, 8'h00, 1'b0};
      vecs[6]  = '{8'h5A, 2'b00, 1'b0, 4'd0,  1'b0, 8'h5A, 1'b0};
      vecs[7]  = '{8'hC3, 2'b10, 1'b0, 4'd0,  1'b1, 8'h86, 1'b1};
      vecs[8]  = '{8'h80, 2'b01, 1'b0, 4'd0,  1'b1, 8'hC0, 1'b0};
      vecs[9]  = '{8'h00, 2'b00, 1'b1, 4'd4,  1'b0, 8'hF0, 1'b0};
      vecs[10] = '{8'h01, 2'b11, 1'b0, 4'd0,  1'b1, 8'h80, 1'b1};
      vecs[11] = '{8'h7F, 2'b01, 1'b0, 4'd8,  1'b0, 8'h00, 1'b0};

      rst_n = 1'b0; clr = 1'b0; ld = 1'b0; data_in = '0; s_in = 1'b0;
      mode = 2'b00; sft = 1'b0; start = 1'b0; amt = '0;

      #2;
      chk("reset_data", 64'(data_out), 64'h00);
      chk("reset_sout", 64'(s_out), 64'h0);
      chk("reset_busy_done", 64'({busy, done}), 64'h0);

      tick();
      rst_n = 1'b1;
      tick();

      // Table-driven single-step and multi-step vectors.
      for (int i = 0; i < 12; i++) begin
         do_ld(vecs[i].init);
         if (vecs[i].use_sft) begin
            mode = vecs[i].mode;
            s_in = vecs[i].sin;
            sft  = 1'b1;
            tick();
            sft  = 1'b0;
            chk($sformatf("v%0d_sft_busy_done", i), 64'({busy, done}), 64'h0);
         end else begin
            do_start(vecs[i].mode, vecs[i].amt, vecs[i].sin);
            wait_done(n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].amt));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'h1);
         end
         chk($sformatf("v%0d_data", i), 64'(data_out), 64'(vecs[i].exp_dat));
         chk($sformatf("v%0d_sout", i), 64'(s_out), 64'(vecs[i].exp_so));
         tick();
         chk($sformatf("v%0d_idle_after", i), 64'({busy, done}), 64'h0);
      end

      // Busy window and done width; ignored inputs while busy.
      do_ld(8'hB4);
      do_start(2'b01, 4'd3, 1'b0);
      nb = 0;
      nd = 0;
      for (int c = 0; c < 12; c++) begin
         if (busy) nb++;
         if (done) nd++;
         if (c == 0) begin
            mode = 2'b10; amt = 4'd0; sft = 1'b1; s_in = 1'b1;
         end
         if (c == 2) sft = 1'b0;
         tick();
      end
      chk("busy_cycles", 64'(nb), 64'd4);
      chk("done_pulses", 64'(nd), 64'd1);
      chk("latched_mode_data", 64'(data_out), 64'hF6);
      chk("latched_mode_sout", 64'(s_out), 64'h1);

      // ld during a 5-step operation is ignored.
      do_ld(8'h96);
      do_start(2'b00, 4'd5, 1'b0);
      ld = 1'b1; data_in = 8'hFF;
      tick();
      ld = 1'b0;
      wait_done(n);
      chk("ld_busy_latency", 64'(n), 64'd4);
      chk("ld_busy_data", 64'(data_out), 64'h04);
      chk("ld_busy_sout", 64'(s_out), 64'h1);
      tick();

      // clr beats ld.
      clr = 1'b1; ld = 1'b1; data_in = 8'h55;
      tick();
      clr = 1'b0; ld = 1'b0;
      chk("clr_ld_data", 64'(data_out), 64'h00);
      chk("clr_ld_sout", 64'(s_out), 64'h0);

      // clr mid-operation aborts with no done pulse.
      do_ld(8'hF1);
      do_start(2'b00, 4'd6, 1'b1);
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_mid_data", 64'(data_out), 64'h00);
      chk("clr_mid_sout", 64'(s_out), 64'h0);
      chk("clr_mid_busy_done", 64'({busy, done}), 64'h0);
      nd = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done || busy) nd++;
      end
      chk("clr_mid_no_done", 64'(nd), 64'd0);

      // Asynchronous reset mid-operation.
      do_ld(8'hAB);
      do_start(2'b11, 4'd6, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_data", 64'(data_out), 64'h00);
      chk("arst_sout", 64'(s_out), 64'h0);
      chk("arst_busy_done", 64'({busy, done}), 64'h0);
      nd = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done || busy) nd++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done || busy) nd++;
      end
      chk("arst_no_done", 64'(nd), 64'd0);
      do_ld(8'h81);
      do_start(2'b11, 4'd1, 1'b0);
      wait_done(n);
      chk("post_arst_latency", 64'(n), 64'd1);
      chk("post_arst_data", 64'(data_out), 64'hC0);
      chk("post_arst_sout", 64'(s_out), 64'h1);
      tick();
      chk("post_arst_idle", 64'({busy, done}), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
